mini_core_accel_mul_int8: RTL and testbench



---
 rtl/mini_core_accel_mul_int8.sv | 87 ++++++++
 tb/tb_mini_core_accel_mul_int8.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mini_core_accel_mul_int8.sv
// mini_core_accel_mul_int8: signed int8 iterative multiplier that restarts whenever its operand pair changes
// Ports: Clk, Rst (sync, active-high); multiplicand/multiplier (signed int8 levels);
//        result (signed 16-bit product, valid when done=1); done (result matches current operands).
// Optional macro MINI_CORE_ACCEL_MUL_STATS_EN adds mul_cnt/abort_cnt (saturating counters).
module mini_core_accel_mul_int8 #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic [15:0] result,
  output logic        done
`ifdef MINI_CORE_ACCEL_MUL_STATS_EN
  ,
  output logic [15:0] mul_cnt,
  output logic [15:0] abort_cnt
`endif
);
  localparam int N = 8 / BITS_PER_CYCLE;
  localparam logic [2:0] LAST = 3'(N - 1);
  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  typedef enum logic {VALID, BUSY} state_t;
  state_t r_state, w_next;
  logic [7:0]  r_lat_a, r_lat_b, r_mag_a, r_mag_b;
  logic        r_neg, r_done;
  logic [15:0] r_acc, r_result;
  logic [2:0]  r_cnt;
  logic        w_chg, w_fin;
  logic [3:0]  w_sh;
  logic [15:0] w_pp, w_sum;
  always_comb begin
    w_chg  = {multiplicand, multiplier} != {r_lat_a, r_lat_b};
    w_fin  = (r_state == BUSY) && !w_chg && (r_cnt == LAST);
    w_sh   = 4'(r_cnt) * 4'(BITS_PER_CYCLE);
    w_pp   = ({8'h00, r_mag_a} * 16'(r_mag_b[BITS_PER_CYCLE-1:0])) << w_sh;
    w_sum  = r_acc + w_pp;
    w_next = w_chg ? BUSY : w_fin ? VALID : r_state;
  end
  always_ff @(posedge Clk) r_state <= Rst ? VALID : w_next;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_lat_a  <= '0;
      r_lat_b  <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b1;
    end else if (w_chg) begin
      r_lat_a <= multiplicand;
      r_lat_b <= multiplier;
      // |-128| wraps to 8'h80, which is exactly 128 when read unsigned
      r_mag_a <= multiplicand[7] ? -multiplicand : multiplicand;
      r_mag_b <= multiplier[7] ? -multiplier : multiplier;
      r_neg   <= multiplicand[7] ^ multiplier[7];
      r_acc   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (r_state == BUSY) begin
      r_acc   <= w_sum;
      r_mag_b <= r_mag_b >> BITS_PER_CYCLE;
      r_cnt   <= r_cnt + 3'd1;
      if (w_fin) begin
        r_result <= r_neg ? -w_sum : w_sum;
        r_done   <= 1'b1;
      end
    end
  end
  assign result = r_result;
  assign done   = r_done;
`ifdef MINI_CORE_ACCEL_MUL_STATS_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mul_cnt   <= '0;
      abort_cnt <= '0;
    end else begin
      if (w_fin && mul_cnt != 16'hFFFF) mul_cnt <= mul_cnt + 16'd1;
      if (w_chg && r_state == BUSY && abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mini_core_accel_mul_int8.sv
// tb_mini_core_accel_mul_int8: directed-vector bench over all four BITS_PER_CYCLE builds
module tb_mini_core_accel_mul_int8;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ia, ib;
  logic [15:0] res [4];
  logic        dn  [4];
  int          n_chk = 0;
  int          n_err = 0;
`ifdef MINI_CORE_ACCEL_MUL_STATS_EN
  logic [15:0] mc [4];
  logic [15:0] ac [4];
  mini_core_accel_mul_int8 #(.BITS_PER_CYCLE(1)) d1 (.Clk(clk), .Rst(rst), .multiplicand(ia), .multiplier(ib), .result(res[0]), .done(dn[0]), .mul_cnt(mc[0]), .abort_cnt(ac[0]));
  mini_core_accel_mul_int8 #(.BITS_PER_CYCLE(2)) d2 (.Clk(clk), .Rst(rst), .multiplicand(ia), .multiplier(ib), .result(res[1]), .done(dn[1]), .mul_cnt(mc[1]), .abort_cnt(ac[1]));
  mini_core_accel_mul_int8 #(.BITS_PER_CYCLE(4)) d4 (.Clk(clk), .Rst(rst), .multiplicand(ia), .multiplier(ib), .result(res[2]), .done(dn[2]), .mul_cnt(mc[2]), .abort_cnt(ac[2]));
  mini_core_accel_mul_int8 #(.BITS_PER_CYCLE(8)) d8 (.Clk(clk), .Rst(rst), .multiplicand(ia), .multiplier(ib), .result(res[3]), .done(dn[3]), .mul_cnt(mc[3]), .abort_cnt(ac[3]));
`else
  mini_core_accel_mul_int8 #(.BITS_PER_CYCLE(1)) d1 (.Clk(clk), .Rst(rst), .multiplicand(ia), .multiplier(ib), .result(res[0]), .done(dn[0]));
  mini_core_accel_mul_int8 #(.BITS_PER_CYCLE(2)) d2 (.Clk(clk), .Rst(rst), .multiplicand(ia), .multiplier(ib), .result(res[1]), .done(dn[1]));
  mini_core_accel_mul_int8 #(.BITS_PER_CYCLE(4)) d4 (.Clk(clk), .Rst(rst), .multiplicand(ia), .multiplier(ib), .result(res[2]), .done(dn[2]));
  mini_core_accel_mul_int8 #(.BITS_PER_CYCLE(8)) d8 (.Clk(clk), .Rst(rst), .multiplicand(ia), .multiplier(ib), .result(res[3]), .done(dn[3]));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int lat [4];
    int want [4];
    want = '{8, 4, 2, 1};
    lat  = '{-1, -1, -1, -1};
    ia = a;
    ib = b;
    for (int c = 1; c <= 12; c++) begin
      step();
      for (int k = 0; k < 4; k++) if (dn[k] && lat[k] < 0) lat[k] = c - 1;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_lat%0d", tag, k), 16'(lat[k]), 16'(want[k]));
      chk($sformatf("%s_res%0d", tag, k), res[k], exp);
    end
  endtask
  initial begin
    int bad;
    int lat;
    logic [15:0] snap;
    rst = 1'b1;
    ia  = 8'h00;
    ib  = 8'h00;
    step();
    step();
    chk("rst_res", res[0], 16'h0000);
    chk("rst_done", 16'(dn[0]), 16'h0001);
    chk("rst_done8", 16'(dn[3]), 16'h0001);
    rst = 1'b0;
    step();
    chk("idle_done", 16'(dn[0]), 16'h0001);
    run("5x7", 8'h05, 8'h07, 16'h0023);
    for (int i = 0; i < 5; i++) step();
    chk("hold_res", res[0], 16'h0023);
    chk("hold_done", 16'(dn[0]), 16'h0001);
    run("m128sq", 8'h80, 8'h80, 16'h4000);
    run("m3x100", 8'hFD, 8'h64, 16'hFED4);
    run("127xm128", 8'h7F, 8'h80, 16'hC080);
    run("m5x0", 8'hFB, 8'h00, 16'h0000);
    run("m77x53", 8'hB3, 8'h35, 16'hF00F);
    run("6x6", 8'h06, 8'h06, 16'h0024);
`ifdef MINI_CORE_ACCEL_MUL_STATS_EN
    snap = mc[0];
`else
    snap = 16'h0000;
`endif
    bad = 0;
    ia = 8'h06;
    ib = 8'h06;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!dn[0] || res[0] !== 16'h0024) bad++;
    end
    chk("idem_drops", 16'(bad), 16'h0000);
`ifdef MINI_CORE_ACCEL_MUL_STATS_EN
    chk("idem_mulcnt", mc[0], snap);
`endif
    ia = 8'h09;
    ib = 8'h09;
    for (int i = 0; i < 4; i++) step();
    chk("mid_busy", 16'(dn[0]), 16'h0000);
    rst = 1'b1;
    ia  = 8'h00;
    ib  = 8'h00;
    step();
    rst = 1'b0;
    chk("midrst_res", res[0], 16'h0000);
    chk("midrst_done", 16'(dn[0]), 16'h0001);
    step();
    chk("midrst_idle", 16'(dn[0]), 16'h0001);
    run("9x9", 8'h09, 8'h09, 16'h0051);
    rst = 1'b1;
    ia  = 8'h00;
    ib  = 8'h00;
    step();
    rst = 1'b0;
`ifdef MINI_CORE_ACCEL_MUL_STATS_EN
    chk("rst_mulcnt", mc[0], 16'h0000);
`endif
    ia = 8'h0A;
    ib = 8'h0A;
    for (int i = 0; i < 4; i++) step();
    chk("abort_busy", 16'(dn[0]), 16'h0000);
    ia  = 8'h02;
    ib  = 8'h03;
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (dn[0] && lat < 0) lat = c - 1;
    end
    chk("abort_lat", 16'(lat), 16'h0008);
    chk("abort_res", res[0], 16'h0006);
`ifdef MINI_CORE_ACCEL_MUL_STATS_EN
    chk("abort_mulcnt", mc[0], 16'h0001);
    chk("abort_abcnt", ac[0], 16'h0001);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
